sram_bwe_init: RTL and testbench
================================

SRAM_BWE_INIT -- requirements
Module: sram_bwe_init

Interface
REQ-001 Parameter SRAM_LENGTH, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter SRAM_DEPTH, default 16: number of entries; need not be a power of 2.
REQ-003 Parameter WRITE_MODE, default 0: behaviour of a same-address read and write; 0 is read-first, 1 is write-first.
REQ-004 Clock is one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wen  input  1  write request.
REQ-008 wbe  input  SRAM_LENGTH/8  byte write enables; bit i covers data bits [8i+7:8i].
REQ-009 w_addr  input  $clog2(SRAM_DEPTH)  write address.
REQ-010 data_in  input  SRAM_LENGTH  write data.
REQ-011 ren  input  1  read request.
REQ-012 r_addr  input  $clog2(SRAM_DEPTH)  read address.
REQ-013 data_out  output  SRAM_LENGTH  registered read data.
REQ-014 r_valid  output  1  one-cycle pulse marking data_out as valid for a read.
REQ-015 init_busy  output  1  high while memory clear is in progress.

Function
REQ-016 The FSM SHALL have two states, SRAM_INIT and SRAM_READY; reset enters SRAM_INIT with the clear counter at 0.
REQ-017 In SRAM_INIT, the block SHALL write all-zero to entry [counter] each cycle and increment the counter.
REQ-018 When the counter reaches SRAM_DEPTH-1, the FSM SHALL go to SRAM_READY the next cycle; the clear takes exactly SRAM_DEPTH cycles.
REQ-019 init_busy SHALL be 1 exactly while in SRAM_INIT.
REQ-020 wen and ren SHALL be ignored in SRAM_INIT: no write, no r_valid.
REQ-021 In SRAM_READY, on wen, only bytes with wbe[i]=1 at w_addr SHALL update; wen with wbe=0 SHALL leave memory unchanged.
REQ-022 Read latency SHALL be 1 cycle: ren at edge N drives data_out and r_valid=1 after edge N+1.
REQ-023 data_out SHALL hold its last value when ren=0.
REQ-024 If wen and ren target the same address in one cycle, WRITE_MODE=0 SHALL return the pre-write word.
REQ-025 In the same case, WRITE_MODE=1 SHALL return the merged word: new bytes where wbe=1, old bytes elsewhere.
REQ-026 A write to an address >= SRAM_DEPTH SHALL be dropped.
REQ-027 A read from an address >= SRAM_DEPTH SHALL return 0 with r_valid=1.
REQ-028 Simultaneous reads and writes to different addresses SHALL both complete in the same cycle.

Reset
REQ-029 While rst_n=0: data_out=0, r_valid=0, init_busy=1, FSM in SRAM_INIT, counter at 0.
REQ-030 Reset asserted mid-clear or mid-read SHALL abort immediately; a read in flight SHALL NOT produce r_valid.
REQ-031 Reset SHALL restart the clear from entry 0 on deassertion.

Configuration
REQ-032 The macro is SRAM_OUT_REG_EN.
REQ-033 With SRAM_OUT_REG_EN defined, one extra output register stage SHALL be added: read latency 2, r_valid delayed to match, and both stages reset to 0.
REQ-034 Without SRAM_OUT_REG_EN, read latency SHALL be 1 as in REQ-022.

Structure
REQ-035 RVS192_package SHALL hold the sram_state_e enum (SRAM_INIT, SRAM_READY).
REQ-036 RVS192_package SHALL hold the constants SRAM_READ_FIRST=0 and SRAM_WRITE_FIRST=1.
REQ-037 RVS192_package SHALL hold the byte-merge function used for writes and write-first forwarding.
REQ-038 There SHALL be no sub-module; the FSM, storage and output stage SHALL live in one module.

Verification
REQ-039 Default parameters: release rst_n -> init_busy=1 for exactly 16 cycles; then reads of addresses 0..15 return 0x00000000.
REQ-040 Write 0xAABBCCDD to address 3 with wbe=4'b0101 over a word of 0x11223344 -> read of 3 returns 0x11BB33DD one cycle after ren.
REQ-041 WRITE_MODE=1: same-cycle write 0xDEADBEEF, wbe=4'hF and read at address 5 -> data_out=0xDEADBEEF; WRITE_MODE=0 -> the prior value.
REQ-042 SRAM_DEPTH=12: write to address 13 is dropped; read of 13 returns 0 with r_valid=1; address 12 behaves the same.
REQ-043 Assert rst_n=0 at clear cycle 7 -> outputs go to 0 asynchronously; on release the clear reruns for the full SRAM_DEPTH cycles.
REQ-044 SRAM_OUT_REG_EN defined: ren at cycle N -> r_valid and data at N+2; back-to-back reads stream one word per cycle.

Source files
------------

// File: rtl/RVS192_package.sv
// Shared definitions for the byte-write-enable SRAM with self-clearing start-up.
// Holds the controller state encoding, the same-address read/write mode
// constants and the byte merge helper used by the write and forwarding paths.
package RVS192_package;

    typedef enum logic {
        SRAM_INIT  = 1'b0,
        SRAM_READY = 1'b1
    } sram_state_e;

    localparam int SRAM_READ_FIRST  = 0;
    localparam int SRAM_WRITE_FIRST = 1;

    // Pick the incoming byte when its enable is set, otherwise keep the stored byte
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       en);
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sram_bwe_init.sv
// Single-port-per-direction SRAM with byte write enables and an automatic
// zero-fill after reset. One read and one write can complete every cycle.
// Optional macro SRAM_OUT_REG_EN adds a second output register stage, which
// raises the read latency from 1 to 2 cycles.
// SRAM_DEPTH is expected to be at least 2 so the address ports are non-empty.
module sram_bwe_init
    import RVS192_package::*;
#(
    parameter int SRAM_LENGTH = 32,
    parameter int SRAM_DEPTH  = 16,
    parameter int WRITE_MODE  = 0
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wen,
    input  logic [SRAM_LENGTH/8-1:0]      wbe,
    input  logic [$clog2(SRAM_DEPTH)-1:0] w_addr,
    input  logic [SRAM_LENGTH-1:0]        data_in,
    input  logic                          ren,
    input  logic [$clog2(SRAM_DEPTH)-1:0] r_addr,
    output logic [SRAM_LENGTH-1:0]        data_out,
    output logic                          r_valid,
    output logic                          init_busy
);

    localparam int NB = SRAM_LENGTH / 8;
    localparam int AW = $clog2(SRAM_DEPTH);
    localparam logic [AW:0]   DEPTH_LIM  = (AW+1)'(SRAM_DEPTH);
    localparam logic [AW-1:0] LAST_ENTRY = AW'(SRAM_DEPTH - 1);

    logic [SRAM_LENGTH-1:0] mem [SRAM_DEPTH];

    sram_state_e            state;
    logic [AW-1:0]          clr_cnt;
    logic [SRAM_LENGTH-1:0] rd_q;
    logic                   rd_valid_q;

    logic                   w_ok;
    logic                   r_ok;
    logic [SRAM_LENGTH-1:0] w_old;
    logic [SRAM_LENGTH-1:0] w_merged;
    logic [SRAM_LENGTH-1:0] r_word;

    // Addresses past the last entry are legal on the port but never touch storage
    assign w_ok  = ({1'b0, w_addr} < DEPTH_LIM);
    assign r_ok  = ({1'b0, r_addr} < DEPTH_LIM);
    assign w_old = w_ok ? mem[w_addr] : '0;

    // Build the post-write word by overlaying enabled bytes on the stored word
    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            w_merged[8*i +: 8] = byte_merge(w_old[8*i +: 8], data_in[8*i +: 8], wbe[i]);
        end
    end

    // Select read data: out-of-range reads give zero, write-first forwards the merged word
    always_comb begin
        r_word = '0;
        if (r_ok) begin
            if ((WRITE_MODE == SRAM_WRITE_FIRST) && wen && w_ok && (w_addr == r_addr)) begin
                r_word = w_merged;
            end else begin
                r_word = mem[r_addr];
            end
        end
    end

    // Controller: zero-fill sweep after reset, then serve reads into the first output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SRAM_INIT;
            clr_cnt    <= '0;
            init_busy  <= 1'b1;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state)
                SRAM_INIT: begin
                    rd_valid_q <= 1'b0;
                    if (clr_cnt == LAST_ENTRY) begin
                        state     <= SRAM_READY;
                        init_busy <= 1'b0;
                        clr_cnt   <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                SRAM_READY: begin
                    rd_valid_q <= ren;
                    if (ren) begin
                        rd_q <= r_word;
                    end
                end
                default: begin
                    state      <= SRAM_INIT;
                    clr_cnt    <= '0;
                    init_busy  <= 1'b1;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: the clear sweep owns the write port until the controller is ready
    always_ff @(posedge clk) begin
        if (state == SRAM_INIT) begin
            mem[clr_cnt] <= '0;
        end else if (wen && w_ok) begin
            mem[w_addr] <= w_merged;
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [SRAM_LENGTH-1:0] out_q;
    logic                   out_valid_q;

    // Second output stage: follows the first stage one cycle later and holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                out_q <= rd_q;
            end
        end
    end

    assign data_out = out_q;
    assign r_valid  = out_valid_q;
`else
    assign data_out = rd_q;
    assign r_valid  = rd_valid_q;
`endif

endmodule

// File: tb/tb_sram_bwe_init.sv
// Directed bench for sram_bwe_init. Two instances share the stimulus:
// dut_a uses default parameters (depth 16, read-first) and dut_b uses
// depth 12 with write-first, so every vector checks both behaviours.
module tb_sram_bwe_init;

`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [3:0]  wbe;
    logic [3:0]  w_addr;
    logic [31:0] data_in;
    logic        ren;
    logic [3:0]  r_addr;

    logic [31:0] data_out_a, data_out_b;
    logic        r_valid_a, r_valid_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wen;
        logic [3:0]  wbe;
        logic [3:0]  w_addr;
        logic [31:0] data_in;
        logic        ren;
        logic [3:0]  r_addr;
        logic        exp_valid;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [20];

    sram_bwe_init #(.SRAM_LENGTH(32), .SRAM_DEPTH(16), .WRITE_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wbe(wbe), .w_addr(w_addr),
        .data_in(data_in), .ren(ren), .r_addr(r_addr),
        .data_out(data_out_a), .r_valid(r_valid_a), .init_busy(busy_a)
    );

    sram_bwe_init #(.SRAM_LENGTH(32), .SRAM_DEPTH(12), .WRITE_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wbe(wbe), .w_addr(w_addr),
        .data_in(data_in), .ren(ren), .r_addr(r_addr),
        .data_out(data_out_b), .r_valid(r_valid_b), .init_busy(busy_b)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case something stalls the sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        wen = 1'b0; wbe = 4'h0; w_addr = 4'd0; data_in = 32'h0;
        ren = 1'b0; r_addr = 4'd0;
    endtask

    // Drive one vector for one cycle, then idle until its read result is visible
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        wen = v.wen; wbe = v.wbe; w_addr = v.w_addr; data_in = v.data_in;
        ren = v.ren; r_addr = v.r_addr;
        @(negedge clk);
        idleInputs();
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("vec%0d r_valid_a", idx), {31'b0, r_valid_a}, {31'b0, v.exp_valid});
        checkOutput($sformatf("vec%0d r_valid_b", idx), {31'b0, r_valid_b}, {31'b0, v.exp_valid});
        checkOutput($sformatf("vec%0d data_a", idx), data_out_a, v.exp_a);
        checkOutput($sformatf("vec%0d data_b", idx), data_out_b, v.exp_b);
    endtask

    initial begin
        int   cnt_a;
        int   cnt_b;
        vec_t rv;
        logic [3:0]  s_addr [3];
        logic [31:0] s_exp  [3];

        // wen wbe  waddr data          ren raddr valid exp_a          exp_b
        vecs[0]  = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd0,  1'b1, 32'h00000000, 32'h00000000};
        vecs[1]  = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd15, 1'b1, 32'h00000000, 32'h00000000};
        vecs[2]  = '{1'b1, 4'hF, 4'd3,  32'h11223344, 1'b0, 4'd0,  1'b0, 32'h00000000, 32'h00000000};
        vecs[3]  = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd3,  1'b1, 32'h11223344, 32'h11223344};
        vecs[4]  = '{1'b1, 4'h5, 4'd3,  32'hAABBCCDD, 1'b0, 4'd0,  1'b0, 32'h11223344, 32'h11223344};
        vecs[5]  = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd3,  1'b1, 32'h11BB33DD, 32'h11BB33DD};
        vecs[6]  = '{1'b1, 4'hF, 4'd5,  32'hCAFEF00D, 1'b0, 4'd0,  1'b0, 32'h11BB33DD, 32'h11BB33DD};
        vecs[7]  = '{1'b1, 4'hF, 4'd5,  32'hDEADBEEF, 1'b1, 4'd5,  1'b1, 32'hCAFEF00D, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd5,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 4'h0, 4'd5,  32'h00000000, 1'b1, 4'd5,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd5,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 4'hF, 4'd13, 32'h12345678, 1'b1, 4'd13, 1'b1, 32'h00000000, 32'h00000000};
        vecs[12] = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd13, 1'b1, 32'h12345678, 32'h00000000};
        vecs[13] = '{1'b1, 4'hF, 4'd12, 32'h0BADCAFE, 1'b1, 4'd12, 1'b1, 32'h00000000, 32'h00000000};
        vecs[14] = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd12, 1'b1, 32'h0BADCAFE, 32'h00000000};
        vecs[15] = '{1'b1, 4'h8, 4'd7,  32'h99000000, 1'b1, 4'd3,  1'b1, 32'h11BB33DD, 32'h11BB33DD};
        vecs[16] = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd7,  1'b1, 32'h99000000, 32'h99000000};
        vecs[17] = '{1'b1, 4'h6, 4'd7,  32'h00ABCD00, 1'b1, 4'd7,  1'b1, 32'h99000000, 32'h99ABCD00};
        vecs[18] = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b1, 4'd7,  1'b1, 32'h99ABCD00, 32'h99ABCD00};
        vecs[19] = '{1'b0, 4'h0, 4'd0,  32'h00000000, 1'b0, 4'd0,  1'b0, 32'h99ABCD00, 32'h99ABCD00};

        idleInputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset data_a", data_out_a, 32'h0);
        checkOutput("reset data_b", data_out_b, 32'h0);
        checkOutput("reset r_valid_a", {31'b0, r_valid_a}, 32'h0);
        checkOutput("reset busy_a", {31'b0, busy_a}, 32'h1);
        checkOutput("reset busy_b", {31'b0, busy_b}, 32'h1);

        // Abort the clear part way through, then let it rerun in full
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midclear busy_a", {31'b0, busy_a}, 32'h1);
        checkOutput("midclear busy_b", {31'b0, busy_b}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            @(negedge clk);
        end
        checkOutput("clear cycles a", cnt_a, 32'd16);
        checkOutput("clear cycles b", cnt_b, 32'd12);

        $display("[TB] post-clear reads");
        for (int i = 0; i < 16; i++) begin
            rv = '0;
            rv.ren = 1'b1;
            rv.r_addr = 4'(i);
            applyStimulus(rv);
            checkOutput($sformatf("clear rd%0d valid_a", i), {31'b0, r_valid_a}, 32'h1);
            checkOutput($sformatf("clear rd%0d data_a", i), data_out_a, 32'h0);
            checkOutput($sformatf("clear rd%0d data_b", i), data_out_b, 32'h0);
        end

        $display("[TB] vector table");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Back-to-back reads must stream one word per cycle
        $display("[TB] streaming reads");
        s_addr[0] = 4'd3; s_exp[0] = 32'h11BB33DD;
        s_addr[1] = 4'd5; s_exp[1] = 32'hDEADBEEF;
        s_addr[2] = 4'd7; s_exp[2] = 32'h99ABCD00;
        @(negedge clk);
        for (int k = 0; k < 3 + LAT; k++) begin
            if (k >= LAT) begin
                checkOutput($sformatf("stream%0d valid_a", k - LAT), {31'b0, r_valid_a}, 32'h1);
                checkOutput($sformatf("stream%0d data_a", k - LAT), data_out_a, s_exp[k - LAT]);
                checkOutput($sformatf("stream%0d data_b", k - LAT), data_out_b, s_exp[k - LAT]);
            end
            if (k < 3) begin
                ren = 1'b1;
                r_addr = s_addr[k];
            end else begin
                idleInputs();
            end
            @(negedge clk);
        end
        idleInputs();

        // Reset during a read in flight clears outputs at once and suppresses r_valid
        $display("[TB] reset mid-read");
        ren = 1'b1;
        r_addr = 4'd3;
        @(posedge clk);
        #2 rst_n = 1'b0;
        idleInputs();
        #1;
        checkOutput("abort data_a", data_out_a, 32'h0);
        checkOutput("abort data_b", data_out_b, 32'h0);
        checkOutput("abort r_valid_a", {31'b0, r_valid_a}, 32'h0);
        checkOutput("abort r_valid_b", {31'b0, r_valid_b}, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("abort hold r_valid_a", {31'b0, r_valid_a}, 32'h0);
        rst_n = 1'b1;

        // Requests during the clear must be ignored
        $display("[TB] requests during clear");
        repeat (4) @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            wen = 1'b1; wbe = 4'hF; w_addr = 4'd2; data_in = 32'h12345678;
            ren = 1'b1; r_addr = 4'd2;
            @(negedge clk);
            checkOutput($sformatf("init ren%0d r_valid_a", j), {31'b0, r_valid_a}, 32'h0);
            checkOutput($sformatf("init ren%0d r_valid_b", j), {31'b0, r_valid_b}, 32'h0);
        end
        idleInputs();
        repeat (20) @(negedge clk);
        rv = '0;
        rv.ren = 1'b1;
        rv.r_addr = 4'd2;
        applyStimulus(rv);
        checkOutput("init write dropped a", data_out_a, 32'h0);
        checkOutput("init write dropped b", data_out_b, 32'h0);
        rv.r_addr = 4'd3;
        applyStimulus(rv);
        checkOutput("rerun cleared a", data_out_a, 32'h0);
        checkOutput("rerun cleared b", data_out_b, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
